data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Data-memory stage directly downstream of the processor's load/store unit: it consumes `memory_function`, `memory_request`, `memory_write_address` and `memory_write`, and returns `memory_read`. Stores are posted into a small in-order write buffer and retired into a 256×8 single-port RAM on cycles when the port is free. Loads are served from the RAM with one-cycle latency, with store-to-load forwarding from the buffer. An optional power-on sweep clears the RAM before the first access.

## Interface
- `WB_DEPTH`, 4: write-buffer entries, 2..8.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `memory_function` input 2: command. 00 NOP, 01 LOAD, 10 STORE, 11 LOAD+STORE.
- `memory_request` input 8: load address.
- `memory_write_address` input 8: store address.
- `memory_write` input 8: store data.
- `memory_read` output 8: load result, registered.
- `busy` output 1: high while the unit is in INIT, or while the buffer is full (`wb_count == WB_DEPTH`).
- `overflow` output 1: sticky flag, set when a store is dropped; cleared only by reset.
- `wb_count` output 4: current number of buffer entries.

## Operation
- The FSM has two states, INIT and RUN. INIT exists only with `DMU_CLEAR_EN`; without it, reset enters RUN directly.
- The write buffer is a FIFO of {addr[7:0], data[7:0]}.
  - A STORE enqueues at the tail on the clock edge.
- RAM port arbitration, once per cycle:
  - A LOAD uses the port.
  - Otherwise, if `wb_count > 0` (value at the start of the cycle), the head entry is written to RAM and dequeued.
- LOAD result, captured into `memory_read` at the edge:
  - If any buffer entry's addr equals `memory_request`, the result is the data of the youngest matching entry.
  - Otherwise it is `RAM[memory_request]`.
  - The buffer contents used are those at the start of the cycle. In LOAD+STORE to the same address, the load returns the pre-store value.
- `memory_read` holds its value until the next LOAD.
- Enqueue and dequeue in the same cycle leave `wb_count` unchanged.
- Full buffer (`wb_count == WB_DEPTH`) with a STORE arriving:
  - Without a LOAD: the drain frees the head that cycle and the store is accepted.
  - With a LOAD (function 11): the store is dropped, the buffer is unchanged, and `overflow` is set to 1. The load completes normally.
- NOP with an empty buffer has no state change.
- Addresses are 8-bit and cover the full 0..255 range. The RAM has no wrap logic. The FIFO pointers wrap modulo `WB_DEPTH`.
- RAM contents are not affected by reset. Reset asserted mid-operation discards all buffered stores.

## Timing
- Reset values:
  - `memory_read` = 0x00, `overflow` = 0, `wb_count` = 0.
  - `busy` = 1 with `DMU_CLEAR_EN`, 0 without.
  - FIFO pointers = 0.
- Load latency is 1 cycle: a LOAD sampled at edge N gives valid `memory_read` after edge N.
- Store visibility:
  - A store is visible to forwarding from the cycle after its enqueue edge.
  - It is retired to RAM no earlier than the cycle after its enqueue edge.
- Worst-case retirement: a continuous LOAD stream blocks draining indefinitely. A drain occurs on the first non-LOAD cycle.
- `busy` is combinational from state and `wb_count`. It is advisory; the upstream unit is not stalled by it.

## Configuration
- Macro: `DMU_CLEAR_EN`.
- Defined:
  - After `rst_n` deasserts, the FSM stays in INIT for 256 cycles.
  - In INIT it writes 0x00 to addresses 0..255 in order, one per cycle, and ignores all commands (no enqueue, `memory_read` held).
  - `busy` = 1 during INIT; the FSM then enters RUN.
  - Reset asserted during INIT restarts the sweep at address 0.
- Undefined: no INIT state, no sweep counter; RAM contents are undefined until written; RUN follows reset immediately.

## Test plan
- Reset, then (if enabled) wait 256 cycles; LOAD 0x10 -> `memory_read` = 0x00; with the macro, `busy` falls exactly 256 cycles after reset release.
- STORE 0x3C←0xA5, then LOAD 0x3C on the next cycle -> 0xA5 forwarded; after 3 NOPs, LOAD 0x3C -> 0xA5 from RAM with `wb_count` = 0.
- STORE 0x20←0x11, then STORE 0x20←0x22, then LOAD 0x20 -> 0x22 (youngest entry wins).
- Same-address LOAD+STORE: 0x40 holds 0x07; LOAD+STORE addr 0x40 data 0x99 -> `memory_read` = 0x07; next LOAD 0x40 -> 0x99.
- Fill 4 entries with back-to-back LOAD+STORE (`busy` = 1), then one more LOAD+STORE -> store dropped, `overflow` = 1, `wb_count` = 4. A STORE-only cycle then keeps `wb_count` = 4 and the store is accepted.
- Assert `rst_n` low with 3 buffered stores -> all outputs at reset values; the discarded addresses never reach RAM.

Source files
------------

// File: rtl/data_memory_unit.sv
// Data-memory stage: posted-store write buffer with forwarding in front of a 256x8 single-port RAM.
// Optional power-on RAM clear sweep enabled by defining DMU_CLEAR_EN.
module data_memory_unit #(
  parameter int WB_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] memory_function,
  input  logic [7:0] memory_request,
  input  logic [7:0] memory_write_address,
  input  logic [7:0] memory_write,
  output logic [7:0] memory_read,
  output logic       busy,
  output logic       overflow,
  output logic [3:0] wb_count
);

  localparam int              PW      = $clog2(WB_DEPTH);
  localparam logic [3:0]      DEPTH_C = 4'(WB_DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(WB_DEPTH - 1);
  localparam logic [PW:0]     DEPTH_W = (PW + 1)'(WB_DEPTH);

  // Handshake: none. Every command is taken on the edge it is presented;
  // busy is advisory only and never stalls the upstream unit.

  logic [7:0]    ram     [256];
  logic [7:0]    wb_addr [WB_DEPTH];
  logic [7:0]    wb_data [WB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   slot;

  logic       run;
  logic       is_load;
  logic       is_store;
  logic       full;
  logic       drain;
  logic       accept;
  logic       drop;
  logic       fwd_hit;
  logic [7:0] fwd_data;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef DMU_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t     state;
  logic [7:0] sweep_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      sweep_addr <= '0;
    end else if (state == INIT) begin
      sweep_addr <= sweep_addr + 8'd1;
      if (sweep_addr == 8'hFF) state <= RUN;
    end
  end

  assign run = (state == RUN);
`else
  assign run = 1'b1;
`endif

  assign full     = (wb_count == DEPTH_C);
  assign is_load  = run & memory_function[0];
  assign is_store = run & memory_function[1];
  // The port drains the head only when no load claims it this cycle.
  assign drain    = run & ~memory_function[0] & (wb_count != 4'd0);
  assign accept   = is_store & (~full | drain);
  assign drop     = is_store & ~accept;
  assign busy     = ~run | full;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = {1'b0, head} + (PW + 1)'(i);
      if (slot >= DEPTH_W) slot = slot - DEPTH_W;
      if ((4'(i) < wb_count) && (wb_addr[slot[PW-1:0]] == memory_request)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[slot[PW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      wb_count    <= '0;
      overflow    <= 1'b0;
      memory_read <= '0;
    end else begin
      if (drain)  head <= nxt(head);
      if (accept) tail <= nxt(tail);
      case ({accept, drain})
        2'b10:   wb_count <= wb_count + 4'd1;
        2'b01:   wb_count <= wb_count - 4'd1;
        default: wb_count <= wb_count;
      endcase
      if (drop)    overflow    <= 1'b1;
      if (is_load) memory_read <= fwd_hit ? fwd_data : ram[memory_request];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wb_addr[tail] <= memory_write_address;
      wb_data[tail] <= memory_write;
    end
  end

  // RAM contents survive reset; only the sweep (when built in) clears them.
  always_ff @(posedge clk) begin
`ifdef DMU_CLEAR_EN
    if (state == INIT) ram[sweep_addr] <= 8'h00;
    else
`endif
    if (drain) ram[wb_addr[head]] <= wb_data[head];
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized bench for data_memory_unit against a queue-based reference model.
// Honours DMU_CLEAR_EN the same way as the design.
module tb_data_memory_unit;
  localparam int WB_DEPTH = 4;
`ifdef DMU_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] memory_function = 2'b00;
  logic [7:0] memory_request = '0;
  logic [7:0] memory_write_address = '0;
  logic [7:0] memory_write = '0;
  logic [7:0] memory_read;
  logic       busy;
  logic       overflow;
  logic [3:0] wb_count;

  data_memory_unit #(.WB_DEPTH(WB_DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .memory_function      (memory_function),
    .memory_request       (memory_request),
    .memory_write_address (memory_write_address),
    .memory_write         (memory_write),
    .memory_read          (memory_read),
    .busy                 (busy),
    .overflow             (overflow),
    .wb_count             (wb_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Scoreboard: reference RAM, expected write buffer {addr,data} oldest first
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  m_ram [256];
  logic [15:0] exp_q [$];
  logic [7:0]  exp_rd = '0;
  logic        exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] f, input logic [7:0] req,
                            input logic [7:0] wa, input logic [7:0] wd);
    int n;
    n = exp_q.size();
    if (f[0]) begin
      exp_rd = m_ram[req];
      foreach (exp_q[i]) if (exp_q[i][15:8] == req) exp_rd = exp_q[i][7:0];
    end
    if (!f[0] && n > 0) begin
      m_ram[exp_q[0][15:8]] = exp_q[0][7:0];
      exp_q.delete(0);
    end
    if (f[1]) begin
      if (n == WB_DEPTH && f[0]) exp_ovf = 1'b1;
      else exp_q.push_back({wa, wd});
    end
  endtask

  // Driver: one command per clock, checked 1 time unit after the edge
  task automatic cycle(input logic [1:0] f, input logic [7:0] req,
                       input logic [7:0] wa, input logic [7:0] wd);
    memory_function      = f;
    memory_request       = req;
    memory_write_address = wa;
    memory_write         = wd;
    @(posedge clk);
    model_step(f, req, wa, wd);
    #1;
    check("memory_read", memory_read, exp_rd);
    check("wb_count", wb_count, exp_q.size());
    check("overflow", overflow, exp_ovf);
    check("busy", busy, (exp_q.size() == WB_DEPTH));
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic init_phase;
    if (CLEAR_EN) begin
      for (int k = 1; k <= 256; k++) begin
        memory_function      = 2'($urandom_range(0, 3));
        memory_request       = 8'($urandom_range(0, 255));
        memory_write_address = 8'($urandom_range(0, 255));
        memory_write         = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        check("busy_init", busy, (k < 256));
        check("read_init", memory_read, exp_rd);
        check("count_init", wb_count, 0);
      end
      for (int a = 0; a < 256; a++) m_ram[a] = 8'h00;
    end
    memory_function = 2'b00;
  endtask

  task automatic model_reset;
    exp_q.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
  endtask

  logic [7:0] saved [3];
  logic [7:0] d;

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_read", memory_read, 8'h00);
    check("rst_count", wb_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, CLEAR_EN);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    init_phase();

    if (CLEAR_EN) begin
      cycle(2'b01, 8'h10, 8'h00, 8'h00);
      check("swept_0x10", memory_read, 8'h00);
    end

    // Give every RAM location a known value
    for (int a = 0; a < 256; a++) cycle(2'b10, 8'h00, 8'(a), 8'($urandom_range(0, 255)));
    nops(2);

    // Forwarding, then the same data from RAM
    cycle(2'b10, 8'h00, 8'h3C, 8'hA5);
    cycle(2'b01, 8'h3C, 8'h00, 8'h00);
    check("fwd_3c", memory_read, 8'hA5);
    nops(3);
    cycle(2'b01, 8'h3C, 8'h00, 8'h00);
    check("ram_3c", memory_read, 8'hA5);
    check("ram_3c_cnt", wb_count, 0);

    // Youngest entry wins
    cycle(2'b10, 8'h00, 8'h20, 8'h11);
    cycle(2'b10, 8'h00, 8'h20, 8'h22);
    cycle(2'b01, 8'h20, 8'h00, 8'h00);
    check("youngest_20", memory_read, 8'h22);
    nops(3);

    // LOAD+STORE to the same address sees the pre-store value
    cycle(2'b10, 8'h00, 8'h40, 8'h07);
    nops(2);
    cycle(2'b11, 8'h40, 8'h40, 8'h99);
    check("ls_pre_40", memory_read, 8'h07);
    cycle(2'b01, 8'h40, 8'h00, 8'h00);
    check("ls_post_40", memory_read, 8'h99);
    nops(3);

    // Fill, overflow drop, then full STORE-only accepted
    for (int i = 0; i < 4; i++) cycle(2'b11, 8'h00, 8'(8'h50 + i), 8'(8'hC0 + i));
    check("full_busy", busy, 1);
    cycle(2'b11, 8'h01, 8'h54, 8'hEE);
    check("drop_ovf", overflow, 1);
    check("drop_cnt", wb_count, 4);
    cycle(2'b10, 8'h00, 8'h55, 8'h77);
    check("full_store_cnt", wb_count, 4);
    nops(6);
    cycle(2'b01, 8'h55, 8'h00, 8'h00);
    check("accepted_55", memory_read, 8'h77);
    cycle(2'b01, 8'h54, 8'h00, 8'h00);

    // Random traffic, mostly on a small address window to exercise forwarding
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] ra, wa;
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      wa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      cycle(2'($urandom_range(0, 3)), ra, wa, 8'($urandom_range(0, 255)));
    end
    nops(6);

    // Reset with three stores buffered; they must never reach RAM
    for (int i = 0; i < 3; i++) saved[i] = m_ram[8'hA0 + i];
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      if (d == saved[i]) d = ~d;
      cycle(2'b11, 8'h00, 8'(8'hA0 + i), d);
    end
    check("pre_rst_cnt", wb_count, 3);
    #2 rst_n = 1'b0;
    memory_function = 2'b00;
    #1;
    check("mid_rst_read", memory_read, 8'h00);
    check("mid_rst_count", wb_count, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_busy", busy, CLEAR_EN);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    init_phase();
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, 8'(8'hA0 + i), 8'h00, 8'h00);
      check("discarded", memory_read, CLEAR_EN ? 8'h00 : saved[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
